// File: rtl/fft_sample_loader.sv
// Frame loader for the FFT core: gathers streamed real samples into the
// parallel main_data buffer and hands each full frame to the core.
//
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   enable          arms frame capture
//   sample_in       16-bit two's complement sample
//   sample_valid    sample_in valid this cycle
//   sample_ready    loader accepts a sample this cycle (decoded from state)
//   fft_done        completion pulse from the FFT core
//   fft_start       one-cycle start pulse to the FFT core
//   main_data       N_WORDS x 16 frame buffer, parallel to the core
//   fill_count      samples accepted into the current frame
//   busy            a frame is owned by the core
//   drop_count      saturating count of samples offered while not ready
module fft_sample_loader #(
    parameter int N_WORDS    = 512,
    parameter int INTERLEAVE = 1,
    parameter int DROP_W     = 8
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      enable,
    input  logic [15:0]               sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      fft_done,
    output logic                      fft_start,
    output logic [N_WORDS-1:0][15:0]  main_data,
    output logic [9:0]                fill_count,
    output logic                      busy,
    output logic [DROP_W-1:0]         drop_count
);

    localparam int AW        = $clog2(N_WORDS);
    localparam int FRAME_LEN = (INTERLEAVE != 0) ? N_WORDS / 2 : N_WORDS;
    localparam logic [9:0] FRAME_LAST = 10'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        START,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic            done_held;
    logic            accept;
    logic            drop_event;
    logic            last_accept;
    logic [AW-1:0]   slot;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   im_idx;

    assign sample_ready = (state == FILL);
    assign accept       = sample_valid & sample_ready;
    assign last_accept  = accept & (fill_count == FRAME_LAST);

    // Offers are only counted as drops once capture has been armed.
    assign drop_event = sample_valid & ~sample_ready & (state != IDLE);

    // Interleaved frames put sample k at 2k and its imaginary part at 2k+1.
    assign slot   = AW'(fill_count);
    assign wr_idx = (INTERLEAVE != 0) ? (slot << 1) : slot;
    assign im_idx = wr_idx + AW'(1);

    // Frame buffer: only written on accepts, so it is frozen in every
    // state other than FILL and keeps stale words after an abort.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            main_data <= '0;
        end else if (accept) begin
            main_data[wr_idx] <= sample_in;
            if (INTERLEAVE != 0) begin
                main_data[im_idx] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            fill_count <= '0;
            fft_start  <= 1'b0;
            busy       <= 1'b0;
            done_held  <= 1'b0;
        end else begin
            fft_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= FILL;
                        fill_count <= '0;
                    end
                end
                FILL: begin
                    if (last_accept) begin
                        // fill_count parks at FRAME_LEN until next FILL.
                        fill_count <= fill_count + 10'd1;
                        state      <= START;
                        fft_start  <= 1'b1;
                        busy       <= 1'b1;
                        done_held  <= 1'b0;
                    end else if (!enable) begin
                        // A same-cycle accept is still written by the
                        // buffer block; the partial frame is dropped.
                        state      <= IDLE;
                        fill_count <= '0;
                    end else if (accept) begin
                        fill_count <= fill_count + 10'd1;
                    end
                end
                START: begin
                    // A done pulse this early is remembered for WAIT_DONE.
                    state     <= WAIT_DONE;
                    done_held <= fft_done;
                end
                WAIT_DONE: begin
                    if (fft_done || done_held) begin
                        done_held  <= 1'b0;
                        busy       <= 1'b0;
                        fill_count <= '0;
                        state      <= enable ? FILL : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drop_count <= '0;
        end else if (drop_event && !(&drop_count)) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: interleaved instance u0 and
// non-interleaved instance u1 sharing one clock and reset.
module tb_fft_sample_loader;

    localparam int NW = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;

    logic                 en0, v0, done0;
    logic [15:0]          s0;
    logic                 r0, st0, b0;
    logic [NW-1:0][15:0]  md0;
    logic [9:0]           fc0;
    logic [7:0]           dc0;

    logic                 en1, v1, done1;
    logic [15:0]          s1;
    logic                 r1, st1, b1;
    logic [NW-1:0][15:0]  md1;
    logic [9:0]           fc1;
    logic [7:0]           dc1;

    int n_checks = 0;
    int n_fail   = 0;

    fft_sample_loader #(.N_WORDS(NW), .INTERLEAVE(1), .DROP_W(8)) u0 (
        .clk(clk), .n_rst(n_rst), .enable(en0), .sample_in(s0),
        .sample_valid(v0), .sample_ready(r0), .fft_done(done0),
        .fft_start(st0), .main_data(md0), .fill_count(fc0),
        .busy(b0), .drop_count(dc0)
    );

    fft_sample_loader #(.N_WORDS(NW), .INTERLEAVE(0), .DROP_W(8)) u1 (
        .clk(clk), .n_rst(n_rst), .enable(en1), .sample_in(s1),
        .sample_valid(v1), .sample_ready(r1), .fft_done(done1),
        .fft_start(st1), .main_data(md1), .fill_count(fc1),
        .busy(b1), .drop_count(dc1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic stream0(input logic [15:0] base, input int n,
                           output int starts);
        starts = 0;
        for (int k = 0; k < n; k++) begin
            s0 = base + 16'(k);
            v0 = 1'b1;
            tick();
            if (st0) starts++;
        end
        v0 = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        n_rst = 1'b0;
        en0 = 0; v0 = 0; done0 = 0; s0 = '0;
        en1 = 0; v1 = 0; done1 = 0; s1 = '0;
        repeat (2) @(posedge clk);
        #3;
        bad = 0;
        for (int j = 0; j < NW; j++) if (md0[j] !== 16'h0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_main_data: %0d nonzero words, expected 0", bad);
        end
        n_checks++;
        if ({st0, r0, b0} !== 3'b000 || fc0 !== 10'd0 || dc0 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: st=%b rdy=%b busy=%b fc=%0d dc=%0d expected all 0",
                     st0, r0, b0, fc0, dc0);
        end
        n_rst = 1'b1;
        tick();
        n_checks++;
        if (r0 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: got %b expected 0", r0);
        end
    endtask

    task automatic test_fill_interleaved;
        int starts;
        en0 = 1'b1;
        tick();
        n_checks++;
        if (r0 !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_ready: got %b expected 1", r0);
        end
        stream0(16'h0001, 256, starts);
        n_checks++;
        if (md0[0] !== 16'h0001 || md0[1] !== 16'h0 ||
            md0[510] !== 16'h0100 || md0[511] !== 16'h0) begin
            n_fail++;
            $display("FAIL il_words: w0=%h w1=%h w510=%h w511=%h expected 0001 0000 0100 0000",
                     md0[0], md0[1], md0[510], md0[511]);
        end
        n_checks++;
        if (fc0 !== 10'd256) begin
            n_fail++;
            $display("FAIL il_fill_count: got %0d expected 256", fc0);
        end
        n_checks++;
        if (starts != 1 || st0 !== 1'b1 || b0 !== 1'b1 || r0 !== 1'b0) begin
            n_fail++;
            $display("FAIL il_start: starts=%0d st=%b busy=%b rdy=%b expected 1 1 1 0",
                     starts, st0, b0, r0);
        end
        tick();
        n_checks++;
        if (st0 !== 1'b0) begin
            n_fail++;
            $display("FAIL il_start_width: got %b expected 0", st0);
        end
    endtask

    task automatic test_wait_drops;
        int rdy_seen;
        int bad;
        rdy_seen = 0;
        v0 = 1'b1;
        repeat (20) begin
            tick();
            if (r0 !== 1'b0) rdy_seen++;
        end
        v0 = 1'b0;
        n_checks++;
        if (rdy_seen != 0 || dc0 !== 8'd20) begin
            n_fail++;
            $display("FAIL wait_drops: ready_cycles=%0d dc=%0d expected 0 20", rdy_seen, dc0);
        end
        bad = 0;
        for (int j = 0; j < NW; j++) begin
            if (j % 2 == 0) begin
                if (md0[j] !== 16'(j / 2 + 1)) bad++;
            end else if (md0[j] !== 16'h0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wait_frozen: %0d words differ, expected 0", bad);
        end
        en0 = 1'b1;
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        n_checks++;
        if (b0 !== 1'b0 || r0 !== 1'b1 || fc0 !== 10'd0) begin
            n_fail++;
            $display("FAIL done_resume: busy=%b rdy=%b fc=%0d expected 0 1 0", b0, r0, fc0);
        end
        s0 = 16'hABCD;
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        n_checks++;
        if (md0[0] !== 16'hABCD || md0[1] !== 16'h0 ||
            md0[2] !== 16'h0002 || fc0 !== 10'd1) begin
            n_fail++;
            $display("FAIL resume_word0: w0=%h w1=%h w2=%h fc=%0d expected abcd 0000 0002 1",
                     md0[0], md0[1], md0[2], fc0);
        end
    endtask

    task automatic test_enable_abort;
        int starts;
        en0 = 1'b0;
        tick();
        n_checks++;
        if (r0 !== 1'b0 || fc0 !== 10'd0 || md0[0] !== 16'hABCD) begin
            n_fail++;
            $display("FAIL abort_idle: rdy=%b fc=%0d w0=%h expected 0 0 abcd", r0, fc0, md0[0]);
        end
        en0 = 1'b1;
        tick();
        starts = 0;
        for (int k = 0; k < 100; k++) begin
            s0 = 16'h2000 + 16'(k);
            v0 = 1'b1;
            if (k == 99) en0 = 1'b0;
            tick();
            if (st0) starts++;
        end
        v0 = 1'b0;
        n_checks++;
        if (r0 !== 1'b0 || fc0 !== 10'd0 || starts != 0) begin
            n_fail++;
            $display("FAIL abort_100: rdy=%b fc=%0d starts=%0d expected 0 0 0", r0, fc0, starts);
        end
        n_checks++;
        if (md0[0] !== 16'h2000 || md0[198] !== 16'h2063 || md0[200] !== 16'h0065) begin
            n_fail++;
            $display("FAIL abort_words: w0=%h w198=%h w200=%h expected 2000 2063 0065",
                     md0[0], md0[198], md0[200]);
        end
        en0 = 1'b1;
        tick();
        stream0(16'h3000, 256, starts);
        n_checks++;
        if (starts != 1 || st0 !== 1'b1 || md0[0] !== 16'h3000 || md0[510] !== 16'h30FF) begin
            n_fail++;
            $display("FAIL refill: starts=%0d st=%b w0=%h w510=%h expected 1 1 3000 30ff",
                     starts, st0, md0[0], md0[510]);
        end
        tick();
    endtask

    task automatic test_drop_saturation;
        v0 = 1'b1;
        repeat (300) tick();
        v0 = 1'b0;
        n_checks++;
        if (dc0 !== 8'd255 || b0 !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_sat: dc=%0d busy=%b expected 255 1", dc0, b0);
        end
        en0 = 1'b0;
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        n_checks++;
        if (b0 !== 1'b0 || r0 !== 1'b0 || dc0 !== 8'd255) begin
            n_fail++;
            $display("FAIL done_to_idle: busy=%b rdy=%b dc=%0d expected 0 0 255", b0, r0, dc0);
        end
    endtask

    task automatic test_done_in_start;
        int starts;
        en0 = 1'b1;
        tick();
        stream0(16'h4000, 256, starts);
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        n_checks++;
        if (b0 !== 1'b1 || st0 !== 1'b0 || r0 !== 1'b0) begin
            n_fail++;
            $display("FAIL held_done_wait: busy=%b st=%b rdy=%b expected 1 0 0", b0, st0, r0);
        end
        tick();
        n_checks++;
        if (b0 !== 1'b0 || r0 !== 1'b1 || fc0 !== 10'd0) begin
            n_fail++;
            $display("FAIL held_done_exit: busy=%b rdy=%b fc=%0d expected 0 1 0", b0, r0, fc0);
        end
    endtask

    task automatic test_async_reset;
        int starts;
        int bad;
        for (int k = 0; k < 37; k++) begin
            s0 = 16'h5000 + 16'(k);
            v0 = 1'b1;
            tick();
        end
        v0 = 1'b0;
        n_checks++;
        if (fc0 !== 10'd37) begin
            n_fail++;
            $display("FAIL pre_reset_fc: got %0d expected 37", fc0);
        end
        #2 n_rst = 1'b0;
        #1;
        bad = 0;
        for (int j = 0; j < NW; j++) if (md0[j] !== 16'h0) bad++;
        n_checks++;
        if (bad != 0 || fc0 !== 10'd0 || r0 !== 1'b0 || dc0 !== 8'd0 || b0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fill: nonzero=%0d fc=%0d rdy=%b dc=%0d busy=%b expected 0 0 0 0 0",
                     bad, fc0, r0, dc0, b0);
        end
        #2 n_rst = 1'b1;
        en0 = 1'b1;
        tick();
        stream0(16'h6000, 256, starts);
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if (st0 !== 1'b0 || b0 !== 1'b0 || fc0 !== 10'd0 || md0[0] !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_start: st=%b busy=%b fc=%0d w0=%h expected 0 0 0 0000",
                     st0, b0, fc0, md0[0]);
        end
        tick();
        n_checks++;
        if (st0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start_suppressed: got %b expected 0", st0);
        end
        #2 n_rst = 1'b1;
        tick();
        stream0(16'h7000, 256, starts);
        tick();
        #2 n_rst = 1'b0;
        #1;
        bad = 0;
        for (int j = 0; j < NW; j++) if (md0[j] !== 16'h0) bad++;
        n_checks++;
        if (bad != 0 || b0 !== 1'b0 || st0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait: nonzero=%0d busy=%b st=%b expected 0 0 0", bad, b0, st0);
        end
        #2 n_rst = 1'b1;
        en0 = 1'b0;
        tick();
    endtask

    task automatic test_no_interleave;
        int k;
        int starts;
        int bad;
        en1 = 1'b1;
        tick();
        n_checks++;
        if (r1 !== 1'b1) begin
            n_fail++;
            $display("FAIL ni_ready: got %b expected 1", r1);
        end
        k = 0;
        starts = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i % 2 == 0) begin
                s1 = 16'(k * 3 + 1);
                v1 = 1'b1;
            end else begin
                v1 = 1'b0;
            end
            done1 = (i == 301);
            tick();
            if (st1) starts++;
            if (i % 2 == 0) k++;
            if (i == 1022) begin
                n_checks++;
                if (st1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ni_start_timing: got %b expected 1", st1);
                end
            end
        end
        v1 = 1'b0;
        done1 = 1'b0;
        n_checks++;
        if (starts != 1 || fc1 !== 10'd512 || b1 !== 1'b1 || dc1 !== 8'd0) begin
            n_fail++;
            $display("FAIL ni_frame: starts=%0d fc=%0d busy=%b dc=%0d expected 1 512 1 0",
                     starts, fc1, b1, dc1);
        end
        bad = 0;
        for (int j = 0; j < NW; j++) if (md1[j] !== 16'(j * 3 + 1)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ni_words: %0d words differ, expected 0", bad);
        end
        tick();
        n_checks++;
        if (b1 !== 1'b1) begin
            n_fail++;
            $display("FAIL ni_done_in_fill_ignored: busy=%b expected 1", b1);
        end
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        n_checks++;
        if (b1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ni_done_exit: busy=%b expected 0", b1);
        end
    endtask

    initial begin
        test_reset();
        test_fill_interleaved();
        test_wait_drops();
        test_enable_abort();
        test_drop_saturation();
        test_done_in_start();
        test_async_reset();
        test_no_interleave();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
